// File: rtl/ccc_lock_sequencer.sv
// Clock-conditioning lock sequencer: synchronizes CCC lock, qualifies it for a stable window,
// then releases fabric reset. Optional lock-loss counter enabled by CCC_LOCK_LOSS_CNT_EN.
module ccc_lock_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       LOCK_IN,
    input  logic       FORCE_RELOCK,
    input  logic       CLR_STICKY,
    output logic       FAB_RESET_N,
    output logic       CLK_GOOD,
    output logic       FAULT,
    output logic       LOCK_LOST,
    output logic [7:0] LOSS_CNT,
    output logic [1:0] STATE
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CNT_W   = 8;

    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_STABILIZE = 2'b01,
        ST_RUN       = 2'b10,
        ST_FAULT     = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 sync_meta_q;
    logic                 lock_s_q;
    logic                 lock_lost_q, lock_lost_d;
    logic                 fab_reset_n_q, clk_good_q, fault_q;
    logic                 restart;
    logic                 loss_event;

    // Two-flop synchronizer for the asynchronous CCC lock
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            sync_meta_q <= LOCK_IN;
            lock_s_q    <= sync_meta_q;
        end
    end

    // Next-state; restart also covers a forced re-entry of WAIT_LOCK
    always_comb begin
        state_d    = state_q;
        restart    = 1'b0;
        loss_event = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (FORCE_RELOCK) begin
                    restart = 1'b1;
                end else if (lock_s_q) begin
                    state_d = ST_STABILIZE;
                    restart = 1'b1;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                    restart = 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (FORCE_RELOCK || !lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    restart = 1'b1;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d    = ST_WAIT_LOCK;
                    restart    = 1'b1;
                    loss_event = 1'b1;
                end else if (FORCE_RELOCK) begin
                    state_d = ST_WAIT_LOCK;
                    restart = 1'b1;
                end
            end
            ST_FAULT: begin
                if (FORCE_RELOCK) begin
                    state_d = ST_WAIT_LOCK;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                restart = 1'b1;
            end
        endcase
        timer_d = restart ? '0 : timer_q + TIMER_W'(1);
        // A loss in the same cycle as a clear wins
        lock_lost_d = loss_event ? 1'b1 : (CLR_STICKY ? 1'b0 : lock_lost_q);
    end

    // Decoded outputs are flopped alongside the state so they cannot glitch on multi-bit changes
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= ST_WAIT_LOCK;
            timer_q       <= '0;
            lock_lost_q   <= 1'b0;
            fab_reset_n_q <= 1'b0;
            clk_good_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            lock_lost_q   <= lock_lost_d;
            fab_reset_n_q <= (state_d == ST_RUN);
            clk_good_q    <= (state_d == ST_RUN);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

`ifdef CCC_LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Saturating loss counter; a coincident clear restarts the count at one
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_event) begin
            if (CLR_STICKY) begin
                loss_cnt_d = CNT_W'(1);
            end else if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
        end else if (CLR_STICKY) begin
            loss_cnt_d = '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign LOSS_CNT = loss_cnt_q;
`else
    assign LOSS_CNT = '0;
`endif

    assign STATE       = state_q;
    assign FAB_RESET_N = fab_reset_n_q;
    assign CLK_GOOD    = clk_good_q;
    assign FAULT       = fault_q;
    assign LOCK_LOST   = lock_lost_q;

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Self-checking bench for ccc_lock_sequencer: directed vector table, hand-written corner
// sequences and randomized lock activity checked against a behavioural model.
module tb_ccc_lock_sequencer;

    localparam int unsigned L = 16;
    localparam int unsigned T = 100;
`ifdef CCC_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int S_WAIT  = 0;
    localparam int S_STAB  = 1;
    localparam int S_RUN   = 2;
    localparam int S_FAULT = 3;

    logic       PCLK = 1'b0;
    logic       PRESETN;
    logic       LOCK_IN;
    logic       FORCE_RELOCK;
    logic       CLR_STICKY;
    logic       FAB_RESET_N;
    logic       CLK_GOOD;
    logic       FAULT;
    logic       LOCK_LOST;
    logic [7:0] LOSS_CNT;
    logic [1:0] STATE;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PCLK = ~PCLK;

    ccc_lock_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .LOCK_IN     (LOCK_IN),
        .FORCE_RELOCK(FORCE_RELOCK),
        .CLR_STICKY  (CLR_STICKY),
        .FAB_RESET_N (FAB_RESET_N),
        .CLK_GOOD    (CLK_GOOD),
        .FAULT       (FAULT),
        .LOCK_LOST   (LOCK_LOST),
        .LOSS_CNT    (LOSS_CNT),
        .STATE       (STATE)
    );

    // Behavioural model: lock history queue, phase, cycles spent in phase, unbounded loss tally
    bit m_hist[$];
    int m_state;
    int m_age;
    bit m_lost;
    int m_losses;

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
        m_state  = S_WAIT;
        m_age    = 0;
        m_lost   = 1'b0;
        m_losses = 0;
    endtask

    task automatic model_edge(input bit lin, input bit frc, input bit clr);
        bit seen;
        bit loss;
        int nxt;
        seen = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(lin);
        loss = 1'b0;
        nxt  = m_state;
        if (m_state == S_RUN && !seen) begin
            nxt  = S_WAIT;
            loss = 1'b1;
        end else if (frc) begin
            nxt = S_WAIT;
        end else if (m_state == S_WAIT) begin
            if (seen) nxt = S_STAB;
            else if (m_age + 1 == int'(T)) nxt = S_FAULT;
        end else if (m_state == S_STAB) begin
            if (!seen) nxt = S_WAIT;
            else if (m_age + 1 == int'(L)) nxt = S_RUN;
        end
        if (nxt != m_state || frc || loss) m_age = 0;
        else m_age = m_age + 1;
        m_state = nxt;
        if (loss) begin
            m_lost   = 1'b1;
            m_losses = clr ? 1 : m_losses + 1;
        end else if (clr) begin
            m_lost   = 1'b0;
            m_losses = 0;
        end
    endtask

    function automatic int exp_cnt(input int c);
        if (!CNT_EN) return 0;
        return (c > 255) ? 255 : c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int es, input int el, input int ec);
        chk({tag, " STATE"},       32'(STATE),       32'(es));
        chk({tag, " FAB_RESET_N"}, 32'(FAB_RESET_N), 32'(es == S_RUN));
        chk({tag, " CLK_GOOD"},    32'(CLK_GOOD),    32'(es == S_RUN));
        chk({tag, " FAULT"},       32'(FAULT),       32'(es == S_FAULT));
        chk({tag, " LOCK_LOST"},   32'(LOCK_LOST),   32'(el));
        chk({tag, " LOSS_CNT"},    32'(LOSS_CNT),    32'(ec));
    endtask

    task automatic step(input bit lin, input bit frc, input bit clr);
        LOCK_IN      = lin;
        FORCE_RELOCK = frc;
        CLR_STICKY   = clr;
        @(posedge PCLK);
        model_edge(lin, frc, clr);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before any further edge
    task automatic apply_reset(input string tag);
        #3;
        PRESETN = 1'b0;
        #1;
        check_all({tag, " async"}, S_WAIT, 0, 0);
        model_reset();
        @(negedge PCLK);
        @(negedge PCLK);
        LOCK_IN      = 1'b0;
        FORCE_RELOCK = 1'b0;
        CLR_STICKY   = 1'b0;
        PRESETN      = 1'b1;
    endtask

    task automatic go_run(input string tag);
        for (int i = 0; i < 200 && m_state != S_RUN; i++) step(1'b1, m_state == S_FAULT, 1'b0);
        chk({tag, " reach RUN"}, 32'(STATE), 32'(S_RUN));
    endtask

    task automatic lose(input bit frc_last, input bit clr_last);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, frc_last, clr_last);
    endtask

    typedef struct {
        int n;
        bit lin;
        bit frc;
        bit clr;
        int es;
        int el;
        int ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int n, bit lin, bit frc, bit clr, int es, int el, int ec);
        vec_t r;
        r.n = n; r.lin = lin; r.frc = frc; r.clr = clr;
        r.es = es; r.el = el; r.ec = exp_cnt(ec);
        return r;
    endfunction

    initial begin
        PRESETN      = 1'b0;
        LOCK_IN      = 1'b0;
        FORCE_RELOCK = 1'b0;
        CLR_STICKY   = 1'b0;

        // lock-up, forced relock, glitch in STABILIZE, loss, timeout, fault recovery
        tbl.push_back(v(2,  1, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(15, 1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_RUN,   0, 0));
        tbl.push_back(v(1,  1, 1, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(10, 1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(15, 1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_RUN,   0, 0));
        tbl.push_back(v(2,  0, 0, 0, S_RUN,   0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_WAIT,  1, 1));
        tbl.push_back(v(2,  1, 0, 0, S_WAIT,  1, 1));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  1, 1));
        tbl.push_back(v(1,  1, 0, 1, S_STAB,  0, 0));
        tbl.push_back(v(2,  0, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(99, 0, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_FAULT, 0, 0));
        tbl.push_back(v(5,  1, 0, 0, S_FAULT, 0, 0));
        tbl.push_back(v(1,  1, 1, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  1, 1, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  1, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(2,  0, 0, 0, S_STAB,  0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(50, 0, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  0, 1, 0, S_WAIT,  0, 0));
        tbl.push_back(v(99, 0, 0, 0, S_WAIT,  0, 0));
        tbl.push_back(v(1,  0, 0, 0, S_FAULT, 0, 0));
        tbl.push_back(v(1,  0, 1, 0, S_WAIT,  0, 0));

        #2;
        check_all("reset", S_WAIT, 0, 0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].lin, tbl[i].frc, tbl[i].clr);
            check_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].el, tbl[i].ec);
        end

        // 300 lock losses saturate the counter
        for (int i = 0; i < 300; i++) begin
            go_run("sat");
            lose(1'b0, 1'b0);
        end
        check_all("saturate", S_WAIT, 1, exp_cnt(255));
        step(1'b0, 1'b0, 1'b1);
        check_all("clr alone", S_WAIT, 0, 0);

        // loss with a coincident force is still a loss
        go_run("loss+force");
        lose(1'b1, 1'b0);
        check_all("loss+force", S_WAIT, 1, exp_cnt(1));

        // clear coincident with a loss leaves exactly one counted loss
        go_run("loss+clr");
        lose(1'b0, 1'b1);
        check_all("loss+clr", S_WAIT, 1, exp_cnt(1));

        go_run("rst run");
        apply_reset("rst mid-RUN");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        chk("pre-rst STABILIZE", 32'(STATE), 32'(S_STAB));
        apply_reset("rst mid-STAB");
        step(1'b0, 1'b0, 1'b0);
        check_all("post-rst", S_WAIT, 0, 0);

        begin
            int run_left;
            bit lvl;
            run_left = 0;
            lvl      = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (run_left == 0) begin
                    lvl = ($urandom_range(0, 3) != 0);
                    if (lvl) run_left = int'($urandom_range(1, 60));
                    else if ($urandom_range(0, 19) == 0) run_left = int'($urandom_range(1, 150));
                    else run_left = int'($urandom_range(1, 6));
                end
                run_left--;
                step(lvl, $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0);
                check_all("rand", m_state, int'(m_lost), exp_cnt(m_losses));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
